// File: rtl/gen3_packet_assembler.sv
// Gen3 packet assembler: splits the 8-lane byte stream into per-packet segments, stores them in a
// FIFO and exposes a packet only once its end marker has been seen. EDB, overflowed and malformed
// packets are rolled back to the committed pointer and never reach the consumer.
// Optional statistics counters are enabled with `define GEN3_ASM_STATS_EN.
module gen3_packet_assembler #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] Data_in,
  input  logic [7:0]  valid,
  input  logic [7:0]  tlpstart,
  input  logic [7:0]  tlpend,
  input  logic [7:0]  tlpedb,
  input  logic [7:0]  dlpstart,
  input  logic [7:0]  dlpend,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_ptype,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_proto,
  output logic        err_ovf
`ifdef GEN3_ASM_STATS_EN
  ,
  output logic [15:0] tlp_cnt,
  output logic [15:0] null_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int unsigned AW = PTR_W - 1;

  typedef enum logic [1:0] {StIdle, StTlp, StDllp, StDiscard} state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
    logic        ptype;
  } entry_t;

  state_e             st_q, st_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               err_proto_q, err_proto_d, err_ovf_q, err_ovf_d;
  logic [1:0]         we;
  logic [AW-1:0]      wa [2];
  entry_t             wd [2];
  entry_t             mem_q [DEPTH];
  entry_t             head;
  logic               pop;

`ifdef GEN3_ASM_STATS_EN
  logic ev_tlp, ev_null, ev_drop;
`endif

  // Lane scan: walks lanes 0..7 updating a working copy of the state and pointers; index 8 flushes
  // the still-open segment of a packet that continues into the next cycle.
  always_comb begin
    state_e           st;
    logic [PTR_W-1:0] wp, cp;
    logic [7:0]       seg_keep;
    logic [63:0]      dmask;
    logic             seg_sop, seg_ptype, stop, close, eop, good;
    logic [1:0]       wcnt;
    logic [2:0]       li;
    we          = '0;
    wa[0]       = '0;
    wa[1]       = '0;
    wd[0]       = '0;
    wd[1]       = '0;
    err_proto_d = 1'b0;
    err_ovf_d   = 1'b0;
`ifdef GEN3_ASM_STATS_EN
    ev_tlp  = 1'b0;
    ev_null = 1'b0;
    ev_drop = 1'b0;
`endif
    st        = st_q;
    wp        = wr_ptr_q;
    cp        = cmt_ptr_q;
    seg_keep  = '0;
    dmask     = '0;
    // An open packet has written nothing yet exactly when wr_ptr still equals cmt_ptr.
    seg_sop   = (wr_ptr_q == cmt_ptr_q);
    seg_ptype = (st_q == StDllp);
    stop      = 1'b0;
    wcnt      = '0;
    good      = 1'b0;
    for (int i = 0; i < 9; i++) begin
      li    = i[2:0];
      close = 1'b0;
      eop   = 1'b0;
      if (i < 8) begin
        if (!stop && valid[li]) begin
          if (tlpstart[li] || dlpstart[li]) begin
            if (st == StTlp || st == StDllp) begin
              wp          = cp;
              err_proto_d = 1'b1;
`ifdef GEN3_ASM_STATS_EN
              ev_drop = 1'b1;
`endif
            end
            if (wcnt == 2'd2) begin
              // Third segment in one cycle: drop the rest of the cycle.
              err_proto_d = 1'b1;
              stop        = 1'b1;
              st          = StDiscard;
`ifdef GEN3_ASM_STATS_EN
              ev_drop = 1'b1;
`endif
            end else begin
              st        = tlpstart[li] ? StTlp : StDllp;
              seg_sop   = 1'b1;
              seg_ptype = !tlpstart[li];
            end
            seg_keep = '0;
          end
          if (!stop && (st == StTlp || st == StDllp)) seg_keep[li] = 1'b1;
          if (!stop && (tlpend[li] || tlpedb[li] || dlpend[li])) begin
            unique case (st)
              StIdle:    err_proto_d = 1'b1;
              StDiscard: st = StIdle;
              default: begin
                good = (st == StTlp) ? tlpend[li] : dlpend[li];
                if (good) begin
                  close = 1'b1;
                  eop   = 1'b1;
                end else begin
                  if (st == StTlp && tlpedb[li]) begin
`ifdef GEN3_ASM_STATS_EN
                    ev_null = 1'b1;
`endif
                  end else begin
                    err_proto_d = 1'b1;
`ifdef GEN3_ASM_STATS_EN
                    ev_drop = 1'b1;
`endif
                  end
                  wp       = cp;
                  st       = StIdle;
                  seg_keep = '0;
                end
              end
            endcase
          end
        end
      end else if (!stop && (st == StTlp || st == StDllp) && seg_keep != '0) begin
        close = 1'b1;
      end
      if (close) begin
        if ((wp - rd_ptr_q) == PTR_W'(DEPTH)) begin
          wp        = cp;
          err_ovf_d = 1'b1;
          st        = eop ? StIdle : StDiscard;
`ifdef GEN3_ASM_STATS_EN
          ev_drop = 1'b1;
`endif
        end else begin
          for (int b = 0; b < 8; b++) dmask[8*b +: 8] = {8{seg_keep[b]}};
          we[wcnt[0]]       = 1'b1;
          wa[wcnt[0]]       = wp[AW-1:0];
          wd[wcnt[0]].data  = Data_in & dmask;
          wd[wcnt[0]].keep  = seg_keep;
          wd[wcnt[0]].sop   = seg_sop;
          wd[wcnt[0]].eop   = eop;
          wd[wcnt[0]].ptype = seg_ptype;
          wp      = wp + PTR_W'(1);
          wcnt    = wcnt + 2'd1;
          seg_sop = 1'b0;
          if (eop) begin
            cp = wp;
            st = StIdle;
`ifdef GEN3_ASM_STATS_EN
            ev_tlp = !seg_ptype;
`endif
          end
        end
        seg_keep = '0;
      end
    end
    st_d      = st;
    wr_ptr_d  = wp;
    cmt_ptr_d = cp;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
  end

  // Control state and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      err_proto_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_proto_q <= err_proto_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Segment storage; the two write slots never target the same entry
  always_ff @(posedge clk) begin
    if (we[0]) mem_q[wa[0]] <= wd[0];
    if (we[1]) mem_q[wa[1]] <= wd[1];
  end

  // Head-of-FIFO outputs, forced to zero while nothing is committed
  always_comb begin
    head      = mem_q[rd_ptr_q[AW-1:0]];
    out_valid = (rd_ptr_q != cmt_ptr_q);
    pop       = out_valid & out_ready;
    out_data  = out_valid ? head.data  : '0;
    out_keep  = out_valid ? head.keep  : '0;
    out_sop   = out_valid ? head.sop   : 1'b0;
    out_eop   = out_valid ? head.eop   : 1'b0;
    out_ptype = out_valid ? head.ptype : 1'b0;
    err_proto = err_proto_q;
    err_ovf   = err_ovf_q;
  end

`ifdef GEN3_ASM_STATS_EN
  logic [15:0] tlp_cnt_q, tlp_cnt_d, null_cnt_q, null_cnt_d, drop_cnt_q, drop_cnt_d;

  // Saturating event counters
  always_comb begin
    tlp_cnt_d  = tlp_cnt_q  + 16'((ev_tlp  && tlp_cnt_q  != 16'hFFFF) ? 1 : 0);
    null_cnt_d = null_cnt_q + 16'((ev_null && null_cnt_q != 16'hFFFF) ? 1 : 0);
    drop_cnt_d = drop_cnt_q + 16'((ev_drop && drop_cnt_q != 16'hFFFF) ? 1 : 0);
    tlp_cnt    = tlp_cnt_q;
    null_cnt   = null_cnt_q;
    drop_cnt   = drop_cnt_q;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt_q  <= '0;
      null_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      tlp_cnt_q  <= tlp_cnt_d;
      null_cnt_q <= null_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_gen3_packet_assembler.sv
// Directed bench for gen3_packet_assembler: a per-cycle vector table plus hand-written
// sequences for overflow, data masking and mid-packet reset.
module tb_gen3_packet_assembler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] Data_in = '0;
  logic [7:0]  valid = '0, tlpstart = '0, tlpend = '0, tlpedb = '0, dlpstart = '0, dlpend = '0;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_sop, out_eop, out_ptype, out_valid, err_proto, err_ovf;

  int n_cmp = 0;
  int n_fail = 0;

  gen3_packet_assembler #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .Data_in(Data_in), .valid(valid), .tlpstart(tlpstart),
    .tlpend(tlpend), .tlpedb(tlpedb), .dlpstart(dlpstart), .dlpend(dlpend),
    .out_data(out_data), .out_keep(out_keep), .out_sop(out_sop), .out_eop(out_eop),
    .out_ptype(out_ptype), .out_valid(out_valid), .out_ready(out_ready),
    .err_proto(err_proto), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v, ts, te, tx, ds, de;
    logic        rdy;
    logic [13:0] exp;  // {valid, keep, sop, eop, ptype, err_proto, err_ovf}
  } vec_t;

  vec_t tv [30];

  function automatic vec_t mk(input logic [7:0] v, ts, te, tx, ds, de, input logic rdy,
                              input logic ev, input logic [7:0] ek, input logic es, ee, ep,
                              input logic epr, eov);
    vec_t r;
    r.v = v; r.ts = ts; r.te = te; r.tx = tx; r.ds = ds; r.de = de; r.rdy = rdy;
    r.exp = {ev, ek, es, ee, ep, epr, eov};
    return r;
  endfunction

  function automatic logic [13:0] obs();
    return {out_valid, out_keep, out_sop, out_eop, out_ptype, err_proto, err_ovf};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, ts, te, tx, ds, de, input logic rdy);
    valid = v; tlpstart = ts; tlpend = te; tlpedb = tx; dlpstart = ds; dlpend = de;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ovf_cnt, ovf_at;
    logic any_vis, any_proto;
    //          valid ts     te     tx     ds     de     rdy  v  keep   s  e  p  pr ov
    tv[0]  = mk(8'hFF, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF, 1, 1, 0, 0, 0);
    tv[1]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[2]  = mk(8'hFF, 8'h10, 8'h00, 8'h00, 8'h01, 8'h08, 0, 1, 8'h0F, 1, 1, 1, 0, 0);
    tv[3]  = mk(8'h0F, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 0, 1, 8'h0F, 1, 1, 1, 0, 0);
    tv[4]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hF0, 1, 0, 0, 0, 0);
    tv[5]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h0F, 0, 1, 0, 0, 0);
    tv[6]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[7]  = mk(8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[8]  = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[9]  = mk(8'hFF, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[10] = mk(8'h0F, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 0, 1, 8'h0F, 1, 1, 0, 0, 0);
    tv[11] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[12] = mk(8'hFF, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    tv[13] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[14] = mk(8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[15] = mk(8'hFF, 8'h08, 8'h80, 8'h00, 8'h00, 8'h00, 0, 1, 8'hF8, 1, 1, 0, 1, 0);
    tv[16] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[17] = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[18] = mk(8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    tv[19] = mk(8'hFF, 8'h11, 8'h82, 8'h00, 8'h04, 8'h08, 0, 1, 8'h03, 1, 1, 0, 1, 0);
    tv[20] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h0C, 1, 1, 1, 0, 0);
    tv[21] = mk(8'hFF, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[22] = mk(8'hFF, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF, 1, 1, 0, 0, 0);
    tv[23] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[24] = mk(8'h0F, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[25] = mk(8'h03, 8'h00, 8'h02, 8'h00, 8'h00, 8'h80, 0, 1, 8'h0F, 1, 0, 0, 0, 0);
    tv[26] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h03, 0, 1, 0, 0, 0);
    tv[27] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    tv[28] = mk(8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 0, 1, 8'h10, 1, 1, 1, 0, 0);
    tv[29] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);

    // Reset values
    #1;
    check("reset_ctl", 64'(obs()), 64'h0);
    check("reset_data", out_data, 64'h0);
    step();
    step();
    rst_n = 1'b1;
    Data_in = 64'hA5A5_5A5A_0F0F_F0F0;

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].ts, tv[i].te, tv[i].tx, tv[i].ds, tv[i].de, tv[i].rdy);
      step();
      check($sformatf("vec%0d", i), 64'(obs()), 64'(tv[i].exp));
    end

    // Data lanes outside keep are zeroed, lanes are not realigned
    Data_in = 64'h1122_3344_5566_7788;
    drive(8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 1'b0);
    step();
    check("data_val", out_data, 64'h0000_3344_5566_7788);
    check("data_keep", 64'(out_keep), 64'h3F);
    check("data_ptype", 64'(out_ptype), 64'h1);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    step();
    check("data_pop", 64'(out_valid), 64'h0);

    // Overflow: 20-cycle TLP into an empty 16-entry FIFO with the consumer stalled
    ovf_cnt = 0; ovf_at = -1; any_vis = 1'b0; any_proto = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(8'hFF, (k == 0) ? 8'h01 : 8'h00, (k == 19) ? 8'h80 : 8'h00, 8'h00, 8'h00, 8'h00,
            1'b0);
      step();
      if (err_ovf) begin
        ovf_cnt++;
        ovf_at = k;
      end
      any_vis   = any_vis | out_valid;
      any_proto = any_proto | err_proto;
    end
    check("ovf_count", 64'(ovf_cnt), 64'd1);
    check("ovf_cycle", 64'(ovf_at), 64'd16);
    check("ovf_hidden", 64'(any_vis), 64'h0);
    check("ovf_noproto", 64'(any_proto), 64'h0);
    drive(8'hFF, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check("ovf_next", 64'(obs()), 64'({1'b1, 8'hFF, 5'b11000}));
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    step();
    check("ovf_drain", 64'(out_valid), 64'h0);

    // Reset mid-packet with three committed entries
    for (int k = 0; k < 3; k++) begin
      drive(8'hFF, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
    end
    drive(8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check("rst_pre", 64'(out_valid), 64'h1);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 64'(obs()), 64'h0);
    check("rst_async_data", out_data, 64'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_empty", 64'(obs()), 64'h0);
    drive(8'hFF, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check("rst_new_pkt", 64'(obs()), 64'({1'b1, 8'hFF, 5'b11000}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
